fsm_rdm_input_writer: RTL and testbench

//  Write side of the RDM input buffer. Packs a stream of 6-bit LLRs into 96-bit words (16 lanes),

---
 rtl/fsm_rdm_input_writer.sv | 158 +++++++++++++++
 tb/tb_fsm_rdm_input_writer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_rdm_input_writer.sv
// fsm_rdm_input_writer: write side of the RDM input buffer.
// Packs 6-bit LLRs into 96-bit words, writes one combine per ping-pong bank,
// and raises a combine request to the RDM for the bank it must read next.
module fsm_rdm_input_writer #(
  parameter int unsigned LLR_W      = 6,
  parameter int unsigned LANES      = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BANK_WORDS = 1024
) (
  input  logic                     i_core_clk,
  input  logic                     i_rx_rstn,
  input  logic [13:0]              i_Current_Combine_E01_Size,
  input  logic                     i_Combine_start,
  input  logic [LLR_W-1:0]         i_LLR_Data,
  input  logic                     i_LLR_Valid,
  output logic                     o_LLR_Ready,
  output logic                     o_Input_Buffer_Wr_En,
  output logic [ADDR_W-1:0]        o_Input_Buffer_Wr_Address,
  output logic [LLR_W*LANES-1:0]   o_Input_Buffer_Wr_Data,
  output logic                     o_Combine_process_request,
  output logic                     o_Combine_Bank_Sel,
  input  logic                     i_Combine_process_done
);

  localparam int unsigned DATA_W = LLR_W * LANES;
  localparam int unsigned E_W    = 14;
  localparam int unsigned LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, WAIT_BANK, FILL, COMMIT} state_e;

  state_e              state_q;
  logic [E_W-1:0]      e_q;
  logic [E_W-1:0]      llr_cnt_q;
  logic [LANE_W-1:0]   lane_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [DATA_W-1:0]   asm_q;
  logic [1:0]          full_q;
  logic                wr_bank_q;
  logic                rd_bank_q;
  logic                ready_q;
  logic                wr_en_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic                accept_c;
  logic                last_c;
  logic                word_done_c;
  logic                release_c;
  logic [ADDR_W-1:0]   bank_base_c;
  logic [DATA_W-1:0]   asm_d;
  logic [1:0]          full_d;
  logic                rd_bank_d;

  // Accept qualifier, word-complete detection and the assembly word with the new LLR merged in
  always_comb begin
    accept_c    = i_LLR_Valid & ready_q;
    last_c      = (llr_cnt_q == (e_q - E_W'(1)));
    word_done_c = accept_c & ((lane_q == LANE_W'(LANES - 1)) | last_c);
    bank_base_c = wr_bank_q ? ADDR_W'(BANK_WORDS) : '0;
    asm_d       = asm_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        asm_d[DATA_W-1-LLR_W*k -: LLR_W] = i_LLR_Data;
      end
    end
  end

  // Bank ownership: commit marks the write bank full, a done pulse releases the read bank
  always_comb begin
    release_c = i_Combine_process_done & full_q[rd_bank_q];
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    if (state_q == COMMIT) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (release_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Writer FSM, lane packing, buffer write port and bank bookkeeping
  always_ff @(posedge i_core_clk) begin
    if (!i_rx_rstn) begin
      state_q    <= IDLE;
      e_q        <= '0;
      llr_cnt_q  <= '0;
      lane_q     <= '0;
      word_idx_q <= '0;
      asm_q      <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      req_q     <= full_d[rd_bank_d];
      case (state_q)
        IDLE: begin
          if (i_Combine_start && (i_Current_Combine_E01_Size != '0)) begin
            e_q     <= i_Current_Combine_E01_Size;
            state_q <= WAIT_BANK;
          end
        end
        WAIT_BANK: begin
          if (!full_q[wr_bank_q]) begin
            lane_q     <= '0;
            word_idx_q <= '0;
            llr_cnt_q  <= '0;
            asm_q      <= '0;
            ready_q    <= 1'b1;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (accept_c) begin
            llr_cnt_q <= llr_cnt_q + E_W'(1);
            if (word_done_c) begin
              wr_en_q    <= 1'b1;
              data_q     <= asm_d;
              addr_q     <= bank_base_c + word_idx_q;
              word_idx_q <= word_idx_q + ADDR_W'(1);
              asm_q      <= '0;
              lane_q     <= '0;
            end else begin
              asm_q  <= asm_d;
              lane_q <= lane_q + LANE_W'(1);
            end
            if (last_c) begin
              ready_q <= 1'b0;
              state_q <= COMMIT;
            end
          end
        end
        COMMIT: begin
          wr_bank_q <= ~wr_bank_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_LLR_Ready               = ready_q;
  assign o_Input_Buffer_Wr_En      = wr_en_q;
  assign o_Input_Buffer_Wr_Address = addr_q;
  assign o_Input_Buffer_Wr_Data    = data_q;
  assign o_Combine_process_request = req_q;
  assign o_Combine_Bank_Sel        = rd_bank_q;

endmodule

// File: tb/tb_fsm_rdm_input_writer.sv
// Bench for fsm_rdm_input_writer: table vectors, hand-built corner sequences
// and randomized combines checked against a bank/word reference model.
module tb_fsm_rdm_input_writer;

  localparam int unsigned LLR_W  = 6;
  localparam int unsigned DATA_W = 96;
  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [13:0]       e_size;
  logic              start;
  logic [LLR_W-1:0]  llr;
  logic              valid;
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              req;
  logic              sel;
  logic              done;

  fsm_rdm_input_writer dut (
    .i_core_clk                 (clk),
    .i_rx_rstn                  (rstn),
    .i_Current_Combine_E01_Size (e_size),
    .i_Combine_start            (start),
    .i_LLR_Data                 (llr),
    .i_LLR_Valid                (valid),
    .o_LLR_Ready                (ready),
    .o_Input_Buffer_Wr_En       (wr_en),
    .o_Input_Buffer_Wr_Address  (wr_addr),
    .o_Input_Buffer_Wr_Data     (wr_data),
    .o_Combine_process_request  (req),
    .o_Combine_Bank_Sel         (sel),
    .i_Combine_process_done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Captured buffer writes
  logic [ADDR_W-1:0] cap_addr[$];
  logic [DATA_W-1:0] cap_data[$];
  always @(negedge clk) begin
    if (wr_en) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  // Reference model: order of full banks awaiting the RDM, and bank pointers
  int          mq[$];
  int          wr_m;
  int          rd_m;
  logic [5:0]  llrs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_word(input int w, input int e);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (w * 16 + k < e) r[DATA_W-1-6*k -: 6] = llrs[w * 16 + k];
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    wr_m = 0;
    rd_m = 0;
  endtask

  task automatic gen_llrs(input int e, input bit rnd);
    llrs.delete();
    for (int m = 0; m < e; m++) llrs.push_back(rnd ? 6'($urandom) : 6'(m % 32));
  endtask

  task automatic start_pulse(input int e);
    @(negedge clk);
    start  = 1'b1;
    e_size = 14'(e);
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Offer llrs[0..n-1] with random valid gaps; returns once the n-th accept is committed to
  task automatic feed(input int n, input int pct, output bit ok);
    int idx = 0;
    int cyc = 0;
    ok = 1'b1;
    while (idx < n) begin
      @(negedge clk);
      valid = ($urandom_range(99) < pct);
      llr   = valid ? llrs[idx] : 6'($urandom);
      if (valid && ready) idx++;
      cyc++;
      if (cyc > n * 40 + 200) begin
        total++;
        bad++;
        $display("FAIL feed_timeout: accepted %0d of %0d", idx, n);
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      rd_m ^= 1;
    end
    chk("done_req", req, mq.size() != 0);
    chk("done_sel", sel, rd_m[0]);
  endtask

  // Feed a whole combine (start already issued) and check write stream and request timing
  task automatic finish_combine(input int e, input int pct, input bit rnd, input bit dac);
    bit ok;
    int nw;
    int bank;
    nw = (e + 15) / 16;
    gen_llrs(e, rnd);
    cap_addr.delete();
    cap_data.delete();
    feed(e, pct, ok);
    if (!ok) begin
      valid = 1'b0;
      return;
    end
    @(negedge clk);
    valid = 1'b0;
    chk("final_wren", wr_en, 1);
    chk("req_before_commit", req, mq.size() != 0);
    if (dac) done = 1'b1;
    bank = wr_m;
    if (dac && mq.size() > 0) begin
      void'(mq.pop_front());
      rd_m ^= 1;
    end
    mq.push_back(wr_m);
    wr_m ^= 1;
    @(negedge clk);
    done = 1'b0;
    chk("req_after_commit", req, 1);
    chk("bank_sel", sel, rd_m[0]);
    chk("ready_after_commit", ready, 0);
    chk("nwrites", cap_addr.size(), nw);
    for (int w = 0; w < nw && w < cap_addr.size(); w++) begin
      chk($sformatf("addr_w%0d", w), cap_addr[w], bank * 1024 + w);
      chk($sformatf("data_w%0d", w), cap_data[w], model_word(w, e));
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rstn = 1'b0;
    valid = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_wren", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_req", req, 0);
    chk("rst_sel", sel, 0);
    chk("rst_ready", ready, 0);
    rstn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int e;
    int pct;
    bit rnd;
    int words;
    int first;
    int last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    bit seen;
    int c;
    rstn = 1'b0; e_size = '0; start = 1'b0; llr = '0; valid = 1'b0; done = 1'b0;
    model_reset();

    vecs[0] = '{e: 138, pct: 100, rnd: 1'b0, words: 9, first: 0,    last: 8};
    vecs[1] = '{e: 138, pct: 60,  rnd: 1'b0, words: 9, first: 1024, last: 1032};
    vecs[2] = '{e: 16,  pct: 100, rnd: 1'b1, words: 1, first: 0,    last: 0};
    vecs[3] = '{e: 17,  pct: 100, rnd: 1'b1, words: 2, first: 1024, last: 1025};
    vecs[4] = '{e: 32,  pct: 70,  rnd: 1'b1, words: 2, first: 0,    last: 1};
    vecs[5] = '{e: 1,   pct: 100, rnd: 1'b1, words: 1, first: 1024, last: 1024};

    apply_reset(3);

    // Table vectors, each combine released by the RDM before the next
    for (int i = 0; i < 6; i++) begin
      start_pulse(vecs[i].e);
      finish_combine(vecs[i].e, vecs[i].pct, vecs[i].rnd, 1'b0);
      chk($sformatf("vec%0d_words", i), cap_addr.size(), vecs[i].words);
      if (cap_addr.size() > 0) begin
        chk($sformatf("vec%0d_first", i), cap_addr[0], vecs[i].first);
        chk($sformatf("vec%0d_last", i), cap_addr[cap_addr.size()-1], vecs[i].last);
      end
      do_done();
    end

    // Both banks full: third combine stalls until a done frees bank 0
    apply_reset(1);
    start_pulse(32); finish_combine(32, 100, 1'b1, 1'b0);
    start_pulse(32); finish_combine(32, 100, 1'b1, 1'b0);
    cap_addr.delete();
    start_pulse(32);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid = 1'b1;
      llr   = 6'($urandom);
      if (ready) seen = 1'b1;
    end
    valid = 1'b0;
    chk("stall_ready", seen, 0);
    chk("stall_writes", cap_addr.size(), 0);
    do_done();
    finish_combine(32, 100, 1'b1, 1'b0);

    // Reset in the middle of a combine discards it
    apply_reset(1);
    start_pulse(138);
    gen_llrs(138, 1'b0);
    feed(20, 100, ok);
    @(negedge clk);
    valid = 1'b0;
    rstn  = 1'b0;
    cap_addr.delete();
    cap_data.delete();
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_wren", wr_en, 0);
    chk("midrst_req", req, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_addr", wr_addr, 0);
    model_reset();
    repeat (10) @(negedge clk);
    chk("midrst_nowrites", cap_addr.size(), 0);
    start_pulse(20);
    finish_combine(20, 100, 1'b1, 1'b0);

    // E=0 start ignored; start during FILL does not change E
    do_done();
    cap_addr.delete();
    start_pulse(0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid = 1'b1;
      if (ready) seen = 1'b1;
    end
    valid = 1'b0;
    chk("e0_ready", seen, 0);
    chk("e0_writes", cap_addr.size(), 0);
    start_pulse(20);
    c = 0;
    while (!ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("fill_reached", ready, 1);
    start_pulse(5);
    finish_combine(20, 100, 1'b1, 1'b0);

    // Randomized combines, done pulses and done coinciding with commit
    for (int i = 0; i < 30; i++) begin
      int e;
      int pct;
      bit dac;
      e   = $urandom_range(1, 200);
      pct = $urandom_range(30, 100);
      if (mq.size() == 2) do_done();
      else if ($urandom_range(99) < 30) do_done();
      dac = ($urandom_range(99) < 25);
      start_pulse(e);
      finish_combine(e, pct, 1'b1, dac);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
